// File: rtl/bcd_char_formatter.sv
// bcd_char_formatter: converts CHANNELS unsigned binary fields into decimal character codes.
// A shared shift-add-3 engine converts one channel at a time. Results collect in shadow
// registers, so the display bus only ever changes all at once, when the last channel is done.
//
// Ports:
//   pclk        rising-edge clock
//   rst         asynchronous reset, active low
//   start       conversion request, sampled only while idle
//   bin_in      CHANNELS packed binary fields, channel c at [c*BIN_W +: BIN_W]
//   busy        conversion in progress
//   done        one-cycle pulse when char_codes/overflow update
//   overflow    per-channel saturation flag (value > 10**DIGITS-1)
//   char_codes  channel c digit d (d=0 is the LSD) at [(c*DIGITS+d)*7 +: 7]
module bcd_char_formatter #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned BIN_W      = 6,
  parameter int unsigned DIGITS     = 2,
  parameter int unsigned BLANK_LZ   = 0,
  parameter logic [6:0]  CHAR_ZERO  = 7'h30,
  parameter logic [6:0]  CHAR_BLANK = 7'h20
) (
  input  logic                           pclk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CHANNELS*BIN_W-1:0]      bin_in,
  output logic                           busy,
  output logic                           done,
  output logic [CHANNELS-1:0]            overflow,
  output logic [CHANNELS*DIGITS*7-1:0]   char_codes
);

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam int unsigned     BcdW   = 4 * DIGITS;
  localparam int unsigned     ChW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned     CntW   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam int unsigned     CodesW = CHANNELS * DIGITS * 7;
  localparam longint unsigned MaxVal = pow10(DIGITS) - 1;

  typedef enum logic [1:0] {StIdle, StShift, StStore} state_e;

  state_e               state_q, state_d;
  logic [ChW-1:0]       ch_q, ch_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]     bin_sh_q, bin_sh_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [BIN_W-1:0]     snap_q [CHANNELS];
  logic [BIN_W-1:0]     snap_d [CHANNELS];
  logic [BcdW-1:0]      dig_sh_q [CHANNELS];
  logic [BcdW-1:0]      dig_sh_d [CHANNELS];
  logic [CHANNELS-1:0]  ovf_sh_q, ovf_sh_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CHANNELS-1:0]  ovf_q, ovf_d;
  logic [CodesW-1:0]    codes_q, codes_d;

  logic                 finish;
  logic                 ovf_now;
  logic [BIN_W-1:0]     cur_val;
  logic [BIN_W-1:0]     nxt_val;
  logic [BcdW-1:0]      bcd_adj;
  logic [3:0]           nib;
  logic [3:0]           map_nib;
  logic                 lead;
  logic [CodesW-1:0]    codes_map;

  // Sequencer, conversion datapath and shadow register updates.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    cnt_d    = cnt_q;
    bin_sh_d = bin_sh_q;
    bcd_d    = bcd_q;
    snap_d   = snap_q;
    dig_sh_d = dig_sh_q;
    ovf_sh_d = ovf_sh_q;
    busy_d   = busy_q;
    finish   = 1'b0;
    cur_val  = '0;
    nxt_val  = '0;
    nib      = '0;
    bcd_adj  = '0;

    for (int c = 0; c < int'(CHANNELS); c++) begin
      if (ChW'(c) == ch_q)        cur_val = snap_q[c];
      if (ChW'(c) == ch_q + 1'b1) nxt_val = snap_q[c];
    end
    ovf_now = 64'(cur_val) > MaxVal;

    for (int n = 0; n < int'(DIGITS); n++) begin
      nib = bcd_q[4*n +: 4];
      bcd_adj[4*n +: 4] = (nib >= 4'd5) ? nib + 4'd3 : nib;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          for (int c = 0; c < int'(CHANNELS); c++) snap_d[c] = bin_in[c*BIN_W +: BIN_W];
          ch_d     = '0;
          cnt_d    = '0;
          bcd_d    = '0;
          bin_sh_d = bin_in[BIN_W-1:0];
          busy_d   = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        // The top BCD bit falls off; STORE saturates any value that would need it.
        bcd_d    = {bcd_adj[BcdW-2:0], bin_sh_q[BIN_W-1]};
        bin_sh_d = bin_sh_q << 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(BIN_W - 1)) state_d = StStore;
      end
      StStore: begin
        for (int c = 0; c < int'(CHANNELS); c++) begin
          if (ChW'(c) == ch_q) begin
            dig_sh_d[c] = ovf_now ? {DIGITS{4'd9}} : bcd_q;
            ovf_sh_d[c] = ovf_now;
          end
        end
        if (ch_q == ChW'(CHANNELS - 1)) begin
          finish  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          ch_d     = ch_q + 1'b1;
          cnt_d    = '0;
          bcd_d    = '0;
          bin_sh_d = nxt_val;
          state_d  = StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Digit-to-character mapping over the next shadow contents, so the last channel's result
  // is included on the same edge it is stored. Saturated digits are 9 and never blank.
  always_comb begin
    codes_map = '0;
    lead      = 1'b1;
    map_nib   = '0;
    for (int c = 0; c < int'(CHANNELS); c++) begin
      lead = 1'b1;
      for (int d = int'(DIGITS) - 1; d >= 0; d--) begin
        map_nib = dig_sh_d[c][4*d +: 4];
        if (map_nib != 4'd0) lead = 1'b0;
        if ((BLANK_LZ != 0) && lead && (d != 0)) begin
          codes_map[(c*int'(DIGITS)+d)*7 +: 7] = CHAR_BLANK;
        end else begin
          codes_map[(c*int'(DIGITS)+d)*7 +: 7] = CHAR_ZERO + {3'b000, map_nib};
        end
      end
    end
  end

  always_comb begin
    done_d  = finish;
    ovf_d   = finish ? ovf_sh_d : ovf_q;
    codes_d = finish ? codes_map : codes_q;
  end

  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      cnt_q    <= '0;
      bin_sh_q <= '0;
      bcd_q    <= '0;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        snap_q[c]   <= '0;
        dig_sh_q[c] <= '0;
      end
      ovf_sh_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= '0;
      codes_q  <= {(CHANNELS*DIGITS){CHAR_ZERO}};
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      cnt_q    <= cnt_d;
      bin_sh_q <= bin_sh_d;
      bcd_q    <= bcd_d;
      for (int c = 0; c < int'(CHANNELS); c++) begin
        snap_q[c]   <= snap_d[c];
        dig_sh_q[c] <= dig_sh_d[c];
      end
      ovf_sh_q <= ovf_sh_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
      codes_q  <= codes_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = ovf_q;
  assign char_codes = codes_q;

endmodule
